// File: rtl/firroot_feeder.sv
// firroot_feeder: loads seven FIR coefficients from a byte-wide host stream, then buffers
// NUM_SAMPLES data bytes through a small FIFO and emits them to the filter at one sample
// per RATE clocks.
//
// Optional feature (macro FIRROOT_FEEDER_ZERO_FLUSH_EN): after the last sample, emit six
// 0x00 samples on successive pace ticks so the filter pipeline drains before Done.
//
// Ports:
//   Clk             single rising-edge clock
//   Rst             synchronous active-high reset
//   Start           run request, honoured only in IDLE
//   In_valid/In_data/In_ready  host byte handshake (coefficients, then samples)
//   B0..B6          coefficient registers, held between runs
//   Data_i/Data_vld sample to the filter, Data_vld high for one cycle per new sample
//   Busy            high whenever the FSM is not IDLE
//   Done            one-cycle end-of-run pulse
module firroot_feeder #(
    parameter int unsigned NUM_SAMPLES = 20,
    parameter int unsigned RATE        = 1,
    parameter int unsigned DEPTH       = 4
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Start,
    input  logic       In_valid,
    input  logic [7:0] In_data,
    output logic       In_ready,
    output logic [7:0] B0,
    output logic [7:0] B1,
    output logic [7:0] B2,
    output logic [7:0] B3,
    output logic [7:0] B4,
    output logic [7:0] B5,
    output logic [7:0] B6,
    output logic [7:0] Data_i,
    output logic       Data_vld,
    output logic       Busy,
    output logic       Done
);

    localparam int unsigned PtrW  = $clog2(DEPTH);
    localparam int unsigned PaceW = (RATE > 1) ? $clog2(RATE) : 1;

    localparam logic [PtrW:0]    FullCnt  = (PtrW + 1)'(DEPTH);
    localparam logic [PaceW-1:0] LastPace = PaceW'(RATE - 1);
    localparam logic [7:0]       NumSamp  = 8'(NUM_SAMPLES);
    localparam logic [7:0]       LastSamp = 8'(NUM_SAMPLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoadCoef,
        StStream,
`ifdef FIRROOT_FEEDER_ZERO_FLUSH_EN
        StFlush,
`endif
        StDone
    } state_t;

    state_t          state_q;
    logic [7:0]      mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW:0]   count_q;
    logic [2:0]      coef_cnt_q;
    logic [7:0]      acc_cnt_q;
    logic [7:0]      pop_cnt_q;
    logic [PaceW-1:0] pace_q;
`ifdef FIRROOT_FEEDER_ZERO_FLUSH_EN
    logic [2:0]      flush_cnt_q;
`endif

    logic fifo_full;
    logic fifo_empty;
    logic tick;
    logic push;
    logic pop;

    // In_ready depends only on registered state, so a full FIFO refuses a push even when
    // a pop happens on the same edge.
    always_comb begin
        fifo_full  = (count_q == FullCnt);
        fifo_empty = (count_q == '0);
        tick       = (pace_q == LastPace);
        In_ready   = 1'b0;
        if (state_q == StLoadCoef) begin
            In_ready = 1'b1;
        end else if (state_q == StStream) begin
            In_ready = !fifo_full && (acc_cnt_q < NumSamp);
        end
        push = In_valid && In_ready && (state_q == StStream);
        pop  = (state_q == StStream) && tick && !fifo_empty;
    end

    assign Busy = (state_q != StIdle);
    assign Done = (state_q == StDone);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= StIdle;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            coef_cnt_q <= '0;
            acc_cnt_q  <= '0;
            pop_cnt_q  <= '0;
            pace_q     <= '0;
            B0         <= '0;
            B1         <= '0;
            B2         <= '0;
            B3         <= '0;
            B4         <= '0;
            B5         <= '0;
            B6         <= '0;
            Data_i     <= '0;
            Data_vld   <= 1'b0;
`ifdef FIRROOT_FEEDER_ZERO_FLUSH_EN
            flush_cnt_q <= '0;
`endif
        end else begin
            Data_vld <= 1'b0;

            if (push) begin
                mem_q[wr_ptr_q] <= In_data;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
                acc_cnt_q       <= acc_cnt_q + 8'd1;
            end
            if (pop) begin
                Data_i    <= mem_q[rd_ptr_q];
                Data_vld  <= 1'b1;
                rd_ptr_q  <= rd_ptr_q + PtrW'(1);
                pop_cnt_q <= pop_cnt_q + 8'd1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (!push && pop) begin
                count_q <= count_q - 1'b1;
            end

            // Free-running wrap; the STREAM entry below restarts it from zero.
            pace_q <= tick ? '0 : pace_q + PaceW'(1);

            case (state_q)
                StIdle: begin
                    if (Start) begin
                        state_q    <= StLoadCoef;
                        coef_cnt_q <= '0;
                        acc_cnt_q  <= '0;
                        pop_cnt_q  <= '0;
                    end
                end
                StLoadCoef: begin
                    if (In_valid) begin
                        case (coef_cnt_q)
                            3'd0:    B0 <= In_data;
                            3'd1:    B1 <= In_data;
                            3'd2:    B2 <= In_data;
                            3'd3:    B3 <= In_data;
                            3'd4:    B4 <= In_data;
                            3'd5:    B5 <= In_data;
                            default: B6 <= In_data;
                        endcase
                        coef_cnt_q <= coef_cnt_q + 3'd1;
                        if (coef_cnt_q == 3'd6) begin
                            state_q <= StStream;
                            pace_q  <= '0;
                        end
                    end
                end
                StStream: begin
                    if (pop && (pop_cnt_q == LastSamp)) begin
`ifdef FIRROOT_FEEDER_ZERO_FLUSH_EN
                        state_q     <= StFlush;
                        flush_cnt_q <= '0;
`else
                        state_q <= StDone;
`endif
                    end
                end
`ifdef FIRROOT_FEEDER_ZERO_FLUSH_EN
                StFlush: begin
                    if (tick) begin
                        Data_i      <= 8'h00;
                        Data_vld    <= 1'b1;
                        flush_cnt_q <= flush_cnt_q + 3'd1;
                        if (flush_cnt_q == 3'd5) begin
                            state_q <= StDone;
                        end
                    end
                end
`endif
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_firroot_feeder.sv
// Self-checking bench for firroot_feeder. Two instances share host inputs: one at RATE=1,
// one at RATE=4 (DEPTH=4). Each has its own Start, so only the selected one leaves IDLE.
// Expected output is the offered byte sequence (plus flush zeros when compiled in), with
// FIFO occupancy tracked from handshakes and pulses.
module tb_firroot_feeder;

    localparam int N = 20;
    localparam int D = 4;
`ifdef FIRROOT_FEEDER_ZERO_FLUSH_EN
    localparam int FLUSH_N = 6;
`else
    localparam int FLUSH_N = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] start;
    logic       in_valid;
    logic [7:0] in_data;

    logic [1:0]            rdy;
    logic [1:0][6:0][7:0]  bb;
    logic [1:0][7:0]       dat;
    logic [1:0]            vld;
    logic [1:0]            busy;
    logic [1:0]            done;

    firroot_feeder #(.NUM_SAMPLES(N), .RATE(1), .DEPTH(D)) dut1 (
        .Clk(clk), .Rst(rst), .Start(start[0]), .In_valid(in_valid), .In_data(in_data),
        .In_ready(rdy[0]), .B0(bb[0][0]), .B1(bb[0][1]), .B2(bb[0][2]), .B3(bb[0][3]),
        .B4(bb[0][4]), .B5(bb[0][5]), .B6(bb[0][6]), .Data_i(dat[0]), .Data_vld(vld[0]),
        .Busy(busy[0]), .Done(done[0])
    );

    firroot_feeder #(.NUM_SAMPLES(N), .RATE(4), .DEPTH(D)) dut4 (
        .Clk(clk), .Rst(rst), .Start(start[1]), .In_valid(in_valid), .In_data(in_data),
        .In_ready(rdy[1]), .B0(bb[1][0]), .B1(bb[1][1]), .B2(bb[1][2]), .B3(bb[1][3]),
        .B4(bb[1][4]), .B5(bb[1][5]), .B6(bb[1][6]), .Data_i(dat[1]), .Data_vld(vld[1]),
        .Busy(busy[1]), .Done(done[1])
    );

    int passed = 0;
    int total  = 0;

    logic [7:0] coef_m [7];
    logic [7:0] samp_m [N];
    logic [7:0] got [$];
    int         vcyc [$];
    int done_cnt, done_cyc, hold_err, pace_err, full_err, saw_full, timeout;

    // One run on instance sel. mode: 0 = In_valid always, 1 = toggling, 2 = random.
    // rst_after > 0 aborts with Rst once that many samples have been seen.
    task automatic run(input int sel, input int mode, input int rst_after, input bit start_mid);
        int occ, occ_prev, coef_idx, samp_idx, popped;
        bit want, mid_sent;
        logic [7:0] last_d, d, nd;
        occ = 0; occ_prev = 0; coef_idx = 0; samp_idx = 0; mid_sent = 1'b0;
        got.delete(); vcyc.delete();
        done_cnt = 0; done_cyc = -10; hold_err = 0; pace_err = 0; full_err = 0;
        saw_full = 0; timeout = 1;
        @(negedge clk); start[sel] = 1'b1;
        @(negedge clk); start[sel] = 1'b0;
        last_d = dat[sel];
        for (int cyc = 0; cyc < 600; cyc++) begin
            start[sel] = 1'b0;
            popped = got.size();
            d = dat[sel];
            if (vld[sel]) begin
                if (popped < N) begin
                    if (occ_prev == 0) pace_err++;
                    occ--;
                end
                got.push_back(d);
                vcyc.push_back(cyc);
            end else if (d !== last_d) begin
                hold_err++;
            end
            // At RATE=1 every cycle is a tick: a pop is due exactly when data was buffered.
            if (sel == 0 && popped < N && !vld[sel] && occ_prev > 0) pace_err++;
            last_d = d;
            if (done[sel]) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (done_cnt > 0 && cyc >= done_cyc + 3) begin
                timeout = 0;
                break;
            end
            if (rst_after > 0 && got.size() == rst_after) begin
                rst = 1'b1; in_valid = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                timeout = 0;
                break;
            end
            if (start_mid && !mid_sent && got.size() == 5) begin
                start[sel] = 1'b1;
                mid_sent = 1'b1;
            end
            if (occ >= D) begin
                saw_full = 1;
                if (rdy[sel] || occ > D) full_err++;
            end
            if (mode == 0) want = 1'b1;
            else if (mode == 1) want = (cyc % 2 == 0);
            else want = ($urandom_range(0, 1) == 1);
            nd = 8'($urandom);
            if (coef_idx < 7) nd = coef_m[coef_idx];
            else if (samp_idx < N) nd = samp_m[samp_idx];
            else want = 1'b0;
            in_valid = want;
            in_data  = nd;
            occ_prev = occ;
            if (want && rdy[sel]) begin
                if (coef_idx < 7) coef_idx++;
                else begin
                    samp_idx++;
                    occ++;
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (timeout != 0) $display("FAIL run_timeout: sel %0d got %0d pulses", sel, got.size());
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 2'b11; in_valid = 1'b1; in_data = 8'hAA;
        repeat (2) @(negedge clk);
        total++;
        if ({rdy, bb, dat, vld, busy, done} !== '0)
            $display("FAIL reset_outputs: got %h required 0", {rdy, bb, dat, vld, busy, done});
        else passed++;
        rst = 1'b0; start = 2'b00; in_valid = 1'b0;
        // Rst and Start together: reset must win.
        @(negedge clk); rst = 1'b1; start[0] = 1'b1;
        @(negedge clk); rst = 1'b0; start[0] = 1'b0;
        total++;
        if (busy[0] !== 1'b0) $display("FAIL reset_over_start: busy %b required 0", busy[0]);
        else passed++;
    endtask

    task automatic test_nominal();
        int bad;
        for (int i = 0; i < 7; i++) coef_m[i] = 8'(i + 1);
        for (int i = 0; i < N; i++) samp_m[i] = 8'(8'h10 + i);
        run(0, 0, 0, 1'b0);
        total++;
        if (got.size() !== N + FLUSH_N)
            $display("FAIL nominal_count: got %0d required %0d", got.size(), N + FLUSH_N);
        else passed++;
        bad = 0;
        for (int i = 0; i < got.size(); i++)
            if (got[i] !== ((i < N) ? samp_m[i] : 8'h00)) bad++;
        total++;
        if (bad != 0) $display("FAIL nominal_order: %0d wrong samples, required 0", bad);
        else passed++;
        for (int i = 0; i < 7; i++) begin
            total++;
            if (bb[0][i] !== coef_m[i])
                $display("FAIL nominal_B%0d: got %h required %h", i, bb[0][i], coef_m[i]);
            else passed++;
        end
        bad = 0;
        for (int i = 1; i < vcyc.size(); i++) if (vcyc[i] - vcyc[i-1] != 1) bad++;
        total++;
        if (bad != 0) $display("FAIL nominal_consecutive: %0d gaps, required 0", bad);
        else passed++;
        total++;
        if (done_cnt !== 1) $display("FAIL nominal_done_count: got %0d required 1", done_cnt);
        else passed++;
        // Done is high the cycle after the final pop edge, alongside that last pulse.
        total++;
        if (vcyc.size() == 0 || done_cyc != vcyc[vcyc.size()-1])
            $display("FAIL nominal_done_timing: done at %0d, last pulse at %0d", done_cyc,
                     (vcyc.size() == 0) ? -1 : vcyc[vcyc.size()-1]);
        else passed++;
        total++;
        if (pace_err != 0 || hold_err != 0)
            $display("FAIL nominal_pacing: pace_err %0d hold_err %0d required 0 0",
                     pace_err, hold_err);
        else passed++;
    endtask

    task automatic test_backpressure();
        int bad;
        for (int i = 0; i < 7; i++) coef_m[i] = 8'($urandom);
        for (int i = 0; i < N; i++) samp_m[i] = 8'($urandom);
        run(1, 0, 0, 1'b0);
        total++;
        if (got.size() !== N + FLUSH_N)
            $display("FAIL bp_count: got %0d required %0d", got.size(), N + FLUSH_N);
        else passed++;
        bad = 0;
        for (int i = 0; i < got.size(); i++)
            if (got[i] !== ((i < N) ? samp_m[i] : 8'h00)) bad++;
        total++;
        if (bad != 0) $display("FAIL bp_order: %0d wrong samples, required 0", bad);
        else passed++;
        bad = 0;
        for (int i = 1; i < vcyc.size(); i++) if (vcyc[i] - vcyc[i-1] != 4) bad++;
        total++;
        if (bad != 0) $display("FAIL bp_spacing: %0d gaps not 4, required 0", bad);
        else passed++;
        total++;
        if (saw_full != 1 || full_err != 0)
            $display("FAIL bp_full_ready: saw_full %0d full_err %0d required 1 0",
                     saw_full, full_err);
        else passed++;
        total++;
        if (done_cnt !== 1 || vcyc.size() == 0 || done_cyc != vcyc[vcyc.size()-1])
            $display("FAIL bp_done: count %0d at %0d required 1 at last pulse", done_cnt,
                     done_cyc);
        else passed++;
    endtask

    task automatic test_starvation();
        int bad;
        for (int m = 1; m <= 2; m++) begin
            for (int i = 0; i < N; i++) samp_m[i] = 8'($urandom);
            run(0, m, 0, 1'b0);
            bad = 0;
            for (int i = 0; i < got.size(); i++)
                if (got[i] !== ((i < N) ? samp_m[i] : 8'h00)) bad++;
            total++;
            if (got.size() !== N + FLUSH_N || bad != 0)
                $display("FAIL starve%0d_stream: %0d pulses %0d wrong, required %0d 0", m,
                         got.size(), bad, N + FLUSH_N);
            else passed++;
            total++;
            if (pace_err != 0 || hold_err != 0)
                $display("FAIL starve%0d_ticks: pace_err %0d hold_err %0d required 0 0", m,
                         pace_err, hold_err);
            else passed++;
            total++;
            if (done_cnt !== 1) $display("FAIL starve%0d_done: got %0d required 1", m, done_cnt);
            else passed++;
        end
    endtask

    task automatic test_reset_midrun();
        int bad;
        for (int i = 0; i < N; i++) samp_m[i] = 8'($urandom);
        run(0, 0, 9, 1'b0);
        total++;
        if ({rdy[0], bb[0], dat[0], vld[0], busy[0], done[0]} !== '0)
            $display("FAIL abort_outputs: got %h required 0",
                     {rdy[0], bb[0], dat[0], vld[0], busy[0], done[0]});
        else passed++;
        total++;
        if (done_cnt !== 0 || got.size() !== 9)
            $display("FAIL abort_no_done: done %0d pulses %0d required 0 9", done_cnt,
                     got.size());
        else passed++;
        // Fresh run after the abort must reload everything.
        for (int i = 0; i < 7; i++) coef_m[i] = 8'($urandom);
        for (int i = 0; i < N; i++) samp_m[i] = 8'($urandom);
        run(0, 2, 0, 1'b0);
        bad = 0;
        for (int i = 0; i < 7; i++) if (bb[0][i] !== coef_m[i]) bad++;
        for (int i = 0; i < got.size(); i++)
            if (got[i] !== ((i < N) ? samp_m[i] : 8'h00)) bad++;
        total++;
        if (bad != 0 || got.size() !== N + FLUSH_N || done_cnt !== 1)
            $display("FAIL reload: %0d wrong, %0d pulses, done %0d, required 0 %0d 1", bad,
                     got.size(), done_cnt, N + FLUSH_N);
        else passed++;
    endtask

    task automatic test_start_during_stream();
        int bad;
        for (int i = 0; i < 7; i++) coef_m[i] = 8'($urandom);
        for (int i = 0; i < N; i++) samp_m[i] = 8'($urandom);
        run(0, 0, 0, 1'b1);
        bad = 0;
        for (int i = 0; i < 7; i++) if (bb[0][i] !== coef_m[i]) bad++;
        for (int i = 0; i < got.size(); i++)
            if (got[i] !== ((i < N) ? samp_m[i] : 8'h00)) bad++;
        total++;
        if (bad != 0 || got.size() !== N + FLUSH_N)
            $display("FAIL start_ignored: %0d wrong, %0d pulses, required 0 %0d", bad,
                     got.size(), N + FLUSH_N);
        else passed++;
        total++;
        if (done_cnt !== 1) $display("FAIL start_ignored_done: got %0d required 1", done_cnt);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_starvation();
        test_reset_midrun();
        test_start_during_stream();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/firroot_feeder.md
FIRROOT_FEEDER -- requirements
Module: firroot_feeder

Interface
REQ-001 The module SHALL have parameter NUM_SAMPLES, default 20, the number of data samples per run, range 1..255.
REQ-002 The module SHALL have parameter RATE, default 1, the output pacing in clocks per emitted sample, range 1..16.
REQ-003 The module SHALL have parameter DEPTH, default 4, the sample FIFO depth, a power of two from 2 to 16.
REQ-004 The module SHALL have port Clk, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-005 The module SHALL have port Rst, input, 1 bit, a synchronous active-high reset.
REQ-006 The module SHALL have port Start, input, 1 bit, a run-request pulse.
REQ-007 The module SHALL have port In_valid, input, 1 bit, meaning the host byte is valid.
REQ-008 The module SHALL have port In_data, input, 8 bits, the host byte (a coefficient or a sample).
REQ-009 The module SHALL have port In_ready, output, 1 bit, meaning the feeder accepts the byte this cycle.
REQ-010 The module SHALL have ports B0..B6, outputs, 8 bits each, the FIR coefficients.
REQ-011 The module SHALL have port Data_i, output, 8 bits, the sample presented to the filter.
REQ-012 The module SHALL have port Data_vld, output, 1 bit, meaning Data_i is new this cycle.
REQ-013 The module SHALL have ports Busy and Done, outputs, 1 bit each: Busy means not IDLE; Done is a one-cycle end-of-run pulse.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, LOAD_COEF, STREAM, FLUSH and DONE.
REQ-015 In IDLE, Start=1 SHALL move the FSM to LOAD_COEF; Start SHALL be ignored in every other state.
REQ-016 A transfer SHALL occur only on a cycle where In_valid=1 and In_ready=1.
REQ-017 In LOAD_COEF, In_ready SHALL be 1, and transfers 0..6 SHALL write B0..B6 in that order.
REQ-018 After the 7th transfer, the FSM SHALL enter STREAM on the next cycle.
REQ-019 B0..B6 SHALL hold their values outside LOAD_COEF, including after DONE.
REQ-020 In STREAM, In_ready SHALL be 1 only when the FIFO is not full and the accepted-sample count is below NUM_SAMPLES; it SHALL be 0 in IDLE, FLUSH and DONE.
REQ-021 A pace counter SHALL clear on entry to STREAM and count 0..RATE-1, wrapping.
REQ-022 When the pace counter equals RATE-1 and the FIFO is non-empty, the module SHALL pop one entry into Data_i (registered) and drive Data_vld=1 for exactly one cycle.
REQ-023 A pace tick with the FIFO empty SHALL be lost, with no pop and Data_vld=0.
REQ-024 When no pop occurs, Data_i SHALL hold its last value and Data_vld SHALL be 0.
REQ-025 A byte accepted at cycle t into an empty FIFO SHALL NOT be visible before t+1; with RATE=1 it SHALL appear on Data_i with Data_vld=1 at t+1.
REQ-026 A simultaneous push and pop SHALL leave the FIFO occupancy unchanged.
REQ-027 A push SHALL never be accepted while the FIFO is full, even if a pop occurs in the same cycle.
REQ-028 FIFO pointers SHALL wrap modulo DEPTH, and order SHALL be strictly FIFO.
REQ-029 After the NUM_SAMPLES-th pop, the FSM SHALL enter FLUSH if the flush feature is compiled in, otherwise DONE.
REQ-030 DONE SHALL last one cycle with Done=1, then return to IDLE.
REQ-031 Busy SHALL be 1 in every state except IDLE.

Reset
REQ-032 Rst=1 at a clock edge SHALL force IDLE, clear the FIFO, pointers and all counters, and set In_ready, B0..B6, Data_i, Data_vld, Busy and Done to 0.
REQ-033 Rst asserted mid-run SHALL abort the run with no Done pulse; Rst SHALL take priority over Start.

Configuration
REQ-034 Macro FIRROOT_FEEDER_ZERO_FLUSH_EN, when defined, SHALL make FLUSH emit 6 samples of value 0x00, one per pace tick with Data_vld=1 each, then enter DONE.
REQ-035 Without FIRROOT_FEEDER_ZERO_FLUSH_EN, the FLUSH state and its counter SHALL NOT be built, and STREAM SHALL go directly to DONE.

Verification
REQ-036 The bench SHALL run a nominal case: RATE=1, Start, 7 coefficient bytes 0x01..0x07, then 20 samples 0x10..0x23 with In_valid always 1 -> B0=0x01..B6=0x07; Data_i=0x10..0x23 on 20 consecutive Data_vld pulses; one Done pulse.
REQ-037 The bench SHALL cover backpressure: RATE=4, DEPTH=4, In_valid held 1 -> In_ready drops when the FIFO is full; Data_vld pulses exactly every 4 cycles; no sample is lost or duplicated.
REQ-038 The bench SHALL cover host starvation: RATE=1, In_valid toggled 1/0 -> Data_vld=0 on starved ticks; Data_i holds its previous value; 20 pulses in order.
REQ-039 The bench SHALL cover the flush feature: with the macro defined and 20 samples -> 6 extra pulses of 0x00 after 0x23, then Done; without the macro, Done is one cycle after the last pop.
REQ-040 The bench SHALL cover reset and Start edge cases: Rst after sample 9 -> all outputs 0, no Done, and a new Start reloads cleanly; Start during STREAM -> ignored, counts unaffected.
